mux_rr_scheduler: RTL and testbench



---
 rtl/mux_rr_scheduler.sv | 101 ++++++++++
 tb/tb_mux_rr_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for the 8-to-1 mux. It issues one registered select and a one-hot
// grant per slot. A slot ends after max(hold_len,1) cycles, or earlier when the owner releases.
module mux_rr_scheduler #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        req,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [2:0]        sel,
  output logic [7:0]        grant,
  output logic              valid,
  output logic              done,
  output logic              fsm_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [2:0]        ptr, ptr_next;
  logic [2:0]        sel_next;
  logic [HOLD_W-1:0] cnt, cnt_next;
  logic              done_next;
  logic [2:0]        pick;
  logic [2:0]        idx;
  logic              found;
  logic [HOLD_W-1:0] hold_eff;

  // Rotating scan: the first set request at or after ptr wins, wrapping modulo 8.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign hold_eff = (hold_len == '0) ? HOLD_W'(1) : hold_len;

  // State register. It also holds the select, the priority pointer, the slot counter and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd0;
      ptr   <= 3'd0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // Next-state logic. The enable is only consulted in IDLE, so a started slot always runs to its end.
  always_comb begin
    state_next = state;
    sel_next   = sel;
    ptr_next   = ptr;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (en && found) begin
          state_next = GRANT;
          sel_next   = pick;
          cnt_next   = hold_eff;
        end
      end
      GRANT: begin
        if (!req[sel] || cnt == HOLD_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
          ptr_next   = sel + 3'd1;
        end else begin
          cnt_next = cnt - HOLD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    valid     = (state == GRANT);
    grant     = valid ? (8'd1 << sel) : 8'd0;
    fsm_state = state;
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed scenarios followed by a random phase.
// A cycle-level reference model and a grant-order scoreboard check the DUT.
module tb_mux_rr_scheduler;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [7:0]    req = 8'h00;
  logic [HW-1:0] hold_len = '0;
  logic [2:0]    sel;
  logic [7:0]    grant;
  logic          valid;
  logic          done;
  logic          fsm_state;

  mux_rr_scheduler #(.HOLD_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .hold_len(hold_len),
    .sel(sel), .grant(grant), .valid(valid), .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: busy = a slot is in progress, left = cycles still allowed in the slot
  bit         m_busy, m_done;
  int         m_sel, m_ptr, m_left;
  logic [2:0] exp_q[$];
  int         sel_log[$];
  int         len_log[$];
  int         cur_len;
  logic       prev_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_sel = 0; m_ptr = 0; m_left = 0;
    exp_q.delete();
    cur_len = 0;
    prev_valid = 1'b0;
  endtask

  // One clock edge of the behaviour described for the scheduler, using the inputs sampled at that edge
  task automatic model_edge();
    if (!m_busy) begin
      m_done = 0;
      if (en && req != 8'h00) begin
        for (int d = 0; d < 8; d++) begin
          if (req[(m_ptr + d) % 8]) begin
            m_sel = (m_ptr + d) % 8;
            break;
          end
        end
        m_left = (hold_len == 0) ? 1 : int'(hold_len);
        m_busy = 1;
        exp_q.push_back(3'(m_sel));
      end
    end else if (!req[m_sel] || m_left == 1) begin
      m_busy = 0;
      m_done = 1;
      m_ptr  = (m_sel + 1) % 8;
    end else begin
      m_left = m_left - 1;
    end
  endtask

  task automatic observe();
    chk("valid", 32'(valid), 32'(m_busy));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("grant", 32'(grant), m_busy ? (32'd1 << m_sel) : 32'd0);
    chk("done", 32'(done), 32'(m_done));
    chk("state", 32'(fsm_state), 32'(m_busy));
    if (valid && !prev_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_sel", 32'(sel), 32'(exp_q.pop_front()));
      sel_log.push_back(int'(sel));
      cur_len = 1;
    end else if (valid) begin
      cur_len++;
    end
    if (!valid && prev_valid) len_log.push_back(cur_len);
    prev_valid = valid;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    observe();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_grants(input string tag, input int count, input int max_cycles);
    int target;
    int n;
    target = sel_log.size() + count;
    n = 0;
    while (sel_log.size() < target && n < max_cycles) begin
      cycle();
      n++;
    end
    chk(tag, 32'(sel_log.size() >= target), 32'd1);
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear without a clock
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic int last_len(input int idx);
    return (len_log.size() > idx) ? len_log[idx] : -1;
  endfunction

  function automatic int log_sel(input int idx);
    return (sel_log.size() > idx) ? sel_log[idx] : -1;
  endfunction

  initial begin
    int base, nsel;
    model_reset();
    run(2);
    rst_n = 1'b1;

    // Single requester, slot of 3, one idle cycle between slots, regrant to the same index
    req = 8'h10; hold_len = 4'd3; en = 1'b1;
    wait_grants("single_to", 2, 40);
    chk("single_sel0", 32'(log_sel(0)), 32'd4);
    chk("single_sel1", 32'(log_sel(1)), 32'd4);
    chk("single_len", 32'(last_len(0)), 32'd3);

    // Reset while a slot is active; afterwards priority restarts at 0
    chk("pre_rst_valid", 32'(valid), 32'd1);
    do_reset();
    req = 8'h01;
    sel_log.delete(); len_log.delete();
    wait_grants("rst_regrant_to", 1, 10);
    chk("rst_regrant_sel", 32'(log_sel(0)), 32'd0);

    // Rotation with wrap, 1-cycle slots
    req = 8'hFF; hold_len = 4'd1;
    sel_log.delete(); len_log.delete();
    wait_grants("rot_to", 10, 80);
    for (int i = 0; i < 10; i++) chk("rot_sel", 32'(log_sel(i)), 32'((i + 1) % 8));
    for (int i = 1; i < 10; i++) chk("rot_len", 32'(last_len(i)), 32'd1);

    // Skip and priority
    do_reset();
    req = 8'h01; hold_len = 4'd1;
    wait_grants("skip0_to", 1, 10);
    req = 8'h81;
    sel_log.delete();
    wait_grants("skip_to", 2, 20);
    chk("skip_first", 32'(log_sel(0)), 32'd7);
    chk("skip_second", 32'(log_sel(1)), 32'd0);
    req = 8'h04;
    wait_grants("prio2_to", 1, 20);
    req = 8'h24;
    sel_log.delete();
    wait_grants("prio_to", 2, 20);
    chk("prio_first", 32'(log_sel(0)), 32'd5);
    chk("prio_second", 32'(log_sel(1)), 32'd2);

    // Early release after 2 cycles of valid; the next scan then starts at 3
    run(4);
    req = 8'h04; hold_len = 4'd5;
    wait_grants("early_to", 1, 20);
    cycle();
    req = 8'h00;
    base = len_log.size();
    cycle();
    chk("early_len", 32'(last_len(base)), 32'd2);
    chk("early_done", 32'(done), 32'd1);
    req = 8'h0C;
    sel_log.delete();
    wait_grants("ptr3_to", 1, 10);
    chk("ptr3_sel", 32'(log_sel(0)), 32'd3);

    // hold_len of 0 behaves as 1
    req = 8'h08; hold_len = 4'd0;
    wait_grants("hold0_to", 2, 30);
    chk("hold0_len", 32'(last_len(len_log.size() - 1)), 32'd1);

    // Enable dropped mid-slot: the slot completes, no regrant until en returns
    run(4);
    req = 8'h02; hold_len = 4'd4;
    wait_grants("en_to", 1, 20);
    en = 1'b0;
    base = len_log.size();
    nsel = sel_log.size();
    run(10);
    chk("en_len", 32'(last_len(base)), 32'd4);
    chk("en_nogrant", 32'(sel_log.size()), 32'(nsel));
    en = 1'b1;
    cycle();
    chk("en_resume", 32'(valid), 32'd1);

    // hold_len changed mid-slot does not affect the running slot
    hold_len = 4'd2;
    base = len_log.size();
    run(6);
    chk("hold_sample_len", 32'(last_len(base)), 32'd4);

    // Random phase
    for (int c = 0; c < 500; c++) begin
      req = 8'($urandom());
      if ($urandom_range(0, 1) == 0) req = req & 8'($urandom());
      en = ($urandom_range(0, 3) != 0);
      hold_len = HW'($urandom_range(0, 6));
      if ($urandom_range(0, 60) == 0) do_reset();
      else cycle();
    end
    en = 1'b0; req = 8'h00;
    run(10);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
